// File: rtl/fp_norm_seq_if.sv
// fp_norm_seq_if: handshake bundle for the normalization sequencer.
//   Input side : in_valid, in_ready, in_sig, in_exp, in_sign
//   Output side: out_valid, out_ready, out_sig, out_exp, out_sign,
//                out_zero, out_under, out_over, out_shifts
// The master modport is the upstream/downstream environment; slave is the sequencer.
interface fp_norm_seq_if #(
  parameter int unsigned SIG_W = 22,
  parameter int unsigned EXP_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [SIG_W-1:0] in_sig;
  logic [EXP_W-1:0] in_exp;
  logic             in_sign;
  logic             out_valid;
  logic             out_ready;
  logic [SIG_W-1:0] out_sig;
  logic [EXP_W-1:0] out_exp;
  logic             out_sign;
  logic             out_zero;
  logic             out_under;
  logic             out_over;
  logic [4:0]       out_shifts;

  modport master (
    output in_valid, in_sig, in_exp, in_sign, out_ready,
    input  in_ready, out_valid, out_sig, out_exp, out_sign,
           out_zero, out_under, out_over, out_shifts
  );

  modport slave (
    input  in_valid, in_sig, in_exp, in_sign, out_ready,
    output in_ready, out_valid, out_sig, out_exp, out_sign,
           out_zero, out_under, out_over, out_shifts
  );
endinterface

// File: rtl/fp_norm_seq.sv
// fp_norm_seq: multi-cycle significand normalizer, one shift per cycle.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : fp_norm_seq_if.slave (input triple and result handshakes)
//   busy  : high whenever the sequencer is not idle
// The hidden bit is moved to SIG_W-2; bit SIG_W-1 is the carry bit. The
// operation stops early on zero, exponent underflow or exponent overflow.
module fp_norm_seq #(
  parameter int unsigned SIG_W = 22,
  parameter int unsigned EXP_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  fp_norm_seq_if.slave       bus,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state;
  logic [SIG_W-1:0] sig_r;
  logic [EXP_W-1:0] exp_r;
  logic             sign_r;
  logic [4:0]       shifts_r;
  logic             zero_r;
  logic             under_r;
  logic             over_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      sig_r    <= '0;
      exp_r    <= '0;
      sign_r   <= 1'b0;
      shifts_r <= '0;
      zero_r   <= 1'b0;
      under_r  <= 1'b0;
      over_r   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          // in_ready is exactly "state == IDLE", so in_valid alone accepts here
          if (bus.in_valid) begin
            sig_r    <= bus.in_sig;
            exp_r    <= bus.in_exp;
            sign_r   <= bus.in_sign;
            shifts_r <= '0;
            zero_r   <= 1'b0;
            under_r  <= 1'b0;
            over_r   <= 1'b0;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          if (sig_r == '0) begin
            zero_r <= 1'b1;
            exp_r  <= '0;
            state  <= DONE;
          end else if (sig_r[SIG_W-1]) begin
            if (exp_r == '1) begin
              over_r <= 1'b1;
              state  <= DONE;
            end else begin
              sig_r    <= sig_r >> 1;
              exp_r    <= exp_r + EXP_W'(1);
              shifts_r <= shifts_r + 5'(1);
            end
          end else if (sig_r[SIG_W-2]) begin
            state <= DONE;
          end else if (exp_r == '0) begin
            under_r <= 1'b1;
            state   <= DONE;
          end else begin
            sig_r    <= sig_r << 1;
            exp_r    <= exp_r - EXP_W'(1);
            shifts_r <= shifts_r + 5'(1);
          end
        end
        DONE: begin
          if (bus.out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready   = (state == IDLE);
  assign bus.out_valid  = (state == DONE);
  assign busy           = (state != IDLE);
  assign bus.out_sig    = sig_r;
  assign bus.out_exp    = exp_r;
  assign bus.out_sign   = sign_r;
  assign bus.out_zero   = zero_r;
  assign bus.out_under  = under_r;
  assign bus.out_over   = over_r;
  assign bus.out_shifts = shifts_r;

endmodule

// File: tb/tb_fp_norm_seq.sv
// tb_fp_norm_seq: directed-vector bench for fp_norm_seq with hand-computed results.
module tb_fp_norm_seq;

  logic clk;
  logic rst_n;
  logic busy;
  int   n_vec;
  int   n_bad;

  fp_norm_seq_if #(.SIG_W(22), .EXP_W(5)) bus ();

  fp_norm_seq #(.SIG_W(22), .EXP_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    end
  endtask

  task automatic issue(input logic [21:0] s, input logic [4:0] e, input logic sg);
    @(negedge clk);
    chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.in_sig   = s;
    bus.in_exp   = e;
    bus.in_sign  = sg;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Called #1 after the accept edge; counts edges until out_valid appears.
  task automatic expect_result(input string tag, input logic [21:0] e_sig, input logic [4:0] e_exp,
                               input logic e_sign, input logic [2:0] e_flags,
                               input logic [4:0] e_sh, input int e_lat);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'(e_lat));
    chk({tag, ".sig"},     32'(bus.out_sig), 32'(e_sig));
    chk({tag, ".exp"},     32'(bus.out_exp), 32'(e_exp));
    chk({tag, ".sign"},    32'(bus.out_sign), 32'(e_sign));
    chk({tag, ".flags"},   32'({bus.out_zero, bus.out_under, bus.out_over}), 32'(e_flags));
    chk({tag, ".shifts"},  32'(bus.out_shifts), 32'(e_sh));
    chk({tag, ".in_ready"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk({tag, ".idle_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, ".idle_out_valid"}, 32'(bus.out_valid), 32'd0);
  endtask

  initial begin
    int seen;
    n_vec = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_sig    = '0;
    bus.in_exp    = '0;
    bus.in_sign   = 1'b0;
    bus.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.in_ready",  32'(bus.in_ready), 32'd1);
    chk("rst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst.busy",      32'(busy), 32'd0);
    chk("rst.sig",       32'(bus.out_sig), 32'd0);
    chk("rst.exp_sign_flags_shifts",
        32'({bus.out_exp, bus.out_sign, bus.out_zero, bus.out_under, bus.out_over, bus.out_shifts}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // flags order: {zero, under, over}
    issue(22'h100000, 5'd10, 1'b1);
    expect_result("norm", 22'h100000, 5'd10, 1'b1, 3'b000, 5'd0, 1);
    release_result("norm");

    issue(22'h200001, 5'd7, 1'b0);
    expect_result("carry", 22'h100000, 5'd8, 1'b0, 3'b000, 5'd1, 2);
    release_result("carry");

    issue(22'h000800, 5'd15, 1'b0);
    expect_result("left9", 22'h100000, 5'd6, 1'b0, 3'b000, 5'd9, 10);
    release_result("left9");

    issue(22'h000010, 5'd3, 1'b1);
    expect_result("under", 22'h000080, 5'd0, 1'b1, 3'b010, 5'd3, 4);
    release_result("under");

    issue(22'h3FFFFF, 5'd31, 1'b0);
    expect_result("over", 22'h3FFFFF, 5'd31, 1'b0, 3'b001, 5'd0, 1);
    release_result("over");

    issue(22'h000000, 5'd12, 1'b1);
    expect_result("zero", 22'h000000, 5'd0, 1'b1, 3'b100, 5'd0, 1);
    release_result("zero");

    // worst case: 20 left shifts
    issue(22'h000001, 5'd31, 1'b0);
    expect_result("worst", 22'h100000, 5'd11, 1'b0, 3'b000, 5'd20, 21);
    release_result("worst");

    // carry landing exactly on the maximum exponent
    issue(22'h200000, 5'd30, 1'b0);
    expect_result("carry_to_max", 22'h100000, 5'd31, 1'b0, 3'b000, 5'd1, 2);
    release_result("carry_to_max");

    // hold in DONE with out_ready low; in_valid high must be ignored
    issue(22'h000800, 5'd15, 1'b1);
    expect_result("hold", 22'h100000, 5'd6, 1'b1, 3'b000, 5'd9, 10);
    bus.in_valid = 1'b1;
    bus.in_sig   = 22'h000001;
    bus.in_exp   = 5'd2;
    for (int unsigned i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("hold.out_valid", 32'(bus.out_valid), 32'd1);
      chk("hold.in_ready",  32'(bus.in_ready), 32'd0);
      chk("hold.sig_exp_shifts", 32'({bus.out_sig, bus.out_exp, bus.out_shifts}),
          32'({22'h100000, 5'd6, 5'd9}));
    end
    bus.in_valid = 1'b0;
    release_result("hold");

    // in_valid held high across two operations
    issue(22'h200001, 5'd7, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_sig   = 22'h100000;
    bus.in_exp   = 5'd3;
    bus.in_sign  = 1'b1;
    expect_result("b2b_a", 22'h100000, 5'd8, 1'b0, 3'b000, 5'd1, 2);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk("b2b.no_accept_in_done_busy", 32'(busy), 32'd0);
    chk("b2b.in_ready_after_done",    32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("b2b.accept_busy",     32'(busy), 32'd1);
    chk("b2b.accept_in_ready", 32'(bus.in_ready), 32'd0);
    expect_result("b2b_b", 22'h100000, 5'd3, 1'b1, 3'b000, 5'd0, 1);
    release_result("b2b_b");

    // reset in the middle of a 9-shift operation
    issue(22'h000800, 5'd15, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.in_ready",  32'(bus.in_ready), 32'd1);
    chk("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst.busy",      32'(busy), 32'd0);
    chk("midrst.sig",       32'(bus.out_sig), 32'd0);
    chk("midrst.exp_sign_flags_shifts",
        32'({bus.out_exp, bus.out_sign, bus.out_zero, bus.out_under, bus.out_over, bus.out_shifts}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int unsigned i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("midrst.no_out_valid", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/fp_norm_seq.md
# fp_norm_seq

Multi-cycle normalization sequencer for the floating-point datapath. It accepts an unnormalized significand/exponent/sign triple over a valid/ready handshake. It then normalizes the significand one bit per cycle so the hidden bit sits at bit SIG_W-2, adjusting the exponent in step. It stops on underflow, overflow or zero and presents the result with status flags on an output valid/ready handshake. It sits between the significand adder/aligner and the rounding/pack stage.

## Interface

- SIG_W, 22: significand width. Bit SIG_W-1 is the carry/overflow bit; bit SIG_W-2 is the hidden-bit position.
- EXP_W, 5: exponent width, unsigned. Range 0 to 2^EXP_W-1.
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, synchronous and active-low. The block has one clock; reset is synchronous and active-low.
- in_valid  in  1  input triple valid.
- in_ready  out  1  high only in IDLE.
- in_sig  in  SIG_W  unnormalized significand.
- in_exp  in  EXP_W  exponent.
- in_sign  in  1  sign; passed through untouched.
- out_valid  out  1  result valid; high only in DONE.
- out_ready  in  1  downstream accepts the result.
- out_sig  out  SIG_W  normalized (or partially normalized) significand.
- out_exp  out  EXP_W  adjusted exponent.
- out_sign  out  1  latched in_sign.
- out_zero  out  1  input significand was zero.
- out_under  out  1  exponent reached 0 before normalization completed.
- out_over  out  1  right shift required with exponent already at maximum.
- out_shifts  out  5  number of shift steps performed.
- busy  out  1  state is not IDLE.

## Operation

- The FSM has three states: IDLE, SHIFT and DONE. Working registers are sig_r, exp_r, sign_r, shifts_r and the three flags.
- IDLE:
  - On in_valid && in_ready, latch in_sig, in_exp and in_sign.
  - Clear shifts_r and all flags.
  - Go to SHIFT.
- SHIFT: each cycle, evaluate sig_r in the following priority order.
  1. sig_r == 0: set zero, force exp_r = 0, go to DONE.
  2. sig_r[SIG_W-1] == 1:
     - If exp_r is at maximum: set over, leave sig_r and exp_r unchanged, go to DONE.
     - Otherwise: sig_r >>= 1 (LSB truncated), exp_r += 1, shifts_r += 1, stay in SHIFT.
  3. sig_r[SIG_W-2] == 1: normalized, go to DONE.
  4. Otherwise:
     - If exp_r == 0: set under, leave sig_r unchanged, go to DONE.
     - Otherwise: sig_r <<= 1 (zero fill), exp_r -= 1, shifts_r += 1, stay in SHIFT.
- DONE:
  - Outputs reflect the working registers and out_valid = 1.
  - Everything is held stable while out_ready = 0.
  - On out_ready, go to IDLE.
- Exponent arithmetic never wraps; it is guarded by the over/under checks.
- At most one right shift occurs per operation. At most SIG_W-2 left shifts occur per operation.
- At most one flag is set per result.
- in_valid is ignored outside IDLE. The upstream holds its data until in_ready.

## Timing

- All outputs are registered or decoded from the state register. There is no combinational path from input to output.
- Reset values: state = IDLE, in_ready = 1, and out_valid, busy, out_sig, out_exp, out_sign, all flags and out_shifts = 0.
- Latency: out_valid rises N+1 clock edges after the accept edge, where N is out_shifts.
  - A zero or already-normalized input gives 1 cycle.
  - The worst case is SIG_W-1 cycles.
- Throughput: a new input is accepted no earlier than the edge after the DONE→IDLE transition. Back-to-back minimum spacing is N+3 cycles.
- If out_ready and in_valid are both high in DONE, nothing is accepted that cycle. in_ready rises the following cycle.
- rst_n low at any edge, including mid-SHIFT or in DONE, aborts the operation. All outputs return to their reset values on that edge and no partial result is emitted.

## Test plan

- Already normalized: sig=0x100000, exp=10, sign=1 → out_valid 1 edge after accept; sig=0x100000, exp=10, sign=1, shifts=0, all flags 0.
- Carry: sig=0x200001, exp=7 → sig=0x100000, exp=8, shifts=1, latency 2, flags 0.
- Left normalize: sig=0x000800, exp=15 → sig=0x100000, exp=6, shifts=9, latency 10.
- Underflow: sig=0x000010, exp=3 → sig=0x000080, exp=0, under=1, shifts=3.
- Overflow and zero:
  - sig=0x3FFFFF, exp=31 → sig=0x3FFFFF, exp=31, over=1, shifts=0.
  - sig=0, exp=12 → zero=1, exp=0, latency 1.
- Handshake and reset:
  - Hold out_ready=0 for 5 cycles in DONE: outputs stay stable and in_ready stays 0.
  - Keep in_valid high throughout: the second input is accepted only after return to IDLE.
  - Assert rst_n=0 during SHIFT of a 9-shift operation: all outputs are 0 on the next edge, in_ready=1, and no out_valid pulse appears.
